// File: rtl/crack_pkg.sv
// Shared types and defaults for the RC4 key-search scheduler and its cracking cores.
package crack_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAIN,
        S_FOUND,
        S_NOT_FOUND
    } crack_state_t;

    localparam int DEFAULT_KEY_WIDTH = 24;
    localparam logic [DEFAULT_KEY_WIDTH-1:0] DEFAULT_MAX_KEY = 24'h3F_FF_FF;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: grants the first idle core strictly after the last granted index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  idle,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(last) + off) % N;
            if (!grant_valid && idle[idx]) begin
                grant[idx]  = 1'b1;
                grant_valid = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/crack_scheduler.sv
// Hands out RC4 candidate keys to NUM_CORES cracking cores and collects their verdicts;
// latches the first winning key and aborts the array, or reports not_found on exhaustion.
module crack_scheduler
    import crack_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = DEFAULT_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] MAX_KEY = KEY_WIDTH'(DEFAULT_MAX_KEY)
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                start,
    output logic [NUM_CORES-1:0]                core_start,
    output logic [NUM_CORES-1:0][KEY_WIDTH-1:0] core_key,
    input  logic [NUM_CORES-1:0]                core_done,
    input  logic [NUM_CORES-1:0]                core_valid,
    output logic                                core_abort,
    output logic                                busy,
    output logic                                found,
    output logic                                not_found,
    output logic [KEY_WIDTH-1:0]                found_key,
    output logic [KEY_WIDTH-1:0]                display_key,
    output crack_state_t                        state_dbg
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    // Core handshake: core_start[i] is a one-cycle valid that qualifies core_key[i]; the
    // core owns that key until its core_done[i] pulse, which carries core_valid[i] as the
    // verdict. There is no ready: a core is only started while its busy bit is clear.
    crack_state_t         state;
    logic [KEY_WIDTH:0]   next_key;
    logic [NUM_CORES-1:0] busy_bits;
    logic [IW-1:0]        last_idx;

    logic [NUM_CORES-1:0] grant, done_eff, hit, busy_nxt;
    logic                 grant_valid, exhausted, dispatch_en;
    logic [IW-1:0]        grant_idx, win_idx;

    // next_key carries one extra bit so the exhaustion test cannot wrap at all-ones MAX_KEY
    assign exhausted   = next_key > {1'b0, MAX_KEY};
    assign done_eff    = core_done & busy_bits;
    assign hit         = done_eff & core_valid;
    assign dispatch_en = (state == S_DISPATCH) && grant_valid && !exhausted && (hit == '0);
    assign busy_nxt    = (busy_bits & ~done_eff) | (dispatch_en ? grant : '0);
    assign display_key = next_key[KEY_WIDTH-1:0];
    assign state_dbg   = state;

    always_comb begin
        win_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit[i]) win_idx = IW'(i);
        end
    end

    rr_pick #(
        .N  (NUM_CORES),
        .IW (IW)
    ) u_pick (
        .idle        (~busy_bits),
        .last        (last_idx),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            next_key   <= '0;
            busy_bits  <= '0;
            last_idx   <= IW'(NUM_CORES - 1);
            core_start <= '0;
            core_key   <= '0;
            core_abort <= 1'b0;
            busy       <= 1'b0;
            found      <= 1'b0;
            not_found  <= 1'b0;
            found_key  <= '0;
        end else begin
            core_start <= '0;
            core_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        found     <= 1'b0;
                        not_found <= 1'b0;
                        found_key <= '0;
                        next_key  <= '0;
                        last_idx  <= IW'(NUM_CORES - 1);
                        busy      <= 1'b1;
                        state     <= S_DISPATCH;
                    end
                end
                S_DISPATCH, S_DRAIN: begin
                    busy_bits <= busy_nxt;
                    if (hit != '0) begin
                        found      <= 1'b1;
                        found_key  <= core_key[win_idx];
                        core_abort <= 1'b1;
                        busy_bits  <= '0;
                        state      <= S_FOUND;
                    end else if (exhausted && busy_nxt == '0) begin
                        not_found <= 1'b1;
                        state     <= S_NOT_FOUND;
                    end else if (exhausted) begin
                        state <= S_DRAIN;
                    end
                    if (dispatch_en) begin
                        core_start           <= grant;
                        core_key[grant_idx]  <= next_key[KEY_WIDTH-1:0];
                        next_key             <= next_key + 1'b1;
                        last_idx             <= grant_idx;
                    end
                end
                S_FOUND, S_NOT_FOUND: begin
                    busy_bits <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
